// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the blocks around it:
// lock and software request in, PLL reset, domain resets and status out.
interface pll_reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   pll_locked;
    logic                   sw_reset_req;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_reset;
    logic                   all_ready;
    logic [2:0]             state_dbg;
    logic [7:0]             relock_count;

    // Sequencer side: watches lock and requests, drives every reset.
    modport master (
        input  pll_locked,
        input  sw_reset_req,
        output pll_rst,
        output domain_reset,
        output all_ready,
        output state_dbg,
        output relock_count
    );

    // Surrounding side: PLL wrapper, software and the reset domains.
    modport slave (
        output pll_locked,
        output sw_reset_req,
        input  pll_rst,
        input  domain_reset,
        input  all_ready,
        input  state_dbg,
        input  relock_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the domain resets one by one in index order. Lock loss sends it
// back to waiting for lock; a software request restarts from the PLL pulse.
module pll_reset_sequencer #(
    parameter int NUM_DOMAINS        = 4,
    parameter int LOCK_SYNC_STAGES   = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int PLLRST_CYCLES      = 32,
    parameter int LOCK_TIMEOUT       = 1000000
) (
    input  logic                  clock,
    input  logic                  resetn,
    pll_reset_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        PLLRST   = 3'd0,
        WAITLOCK = 3'd1,
        STABLE   = 3'd2,
        RELEASE  = 3'd3,
        RUN      = 3'd4
    } state_t;

    // One phase counter serves the PLL pulse, the lock timeout and the
    // release spacing, so it is sized for the largest of the three.
    localparam int PHASE_MAX_A = (PLLRST_CYCLES > STAGE_DELAY) ? PLLRST_CYCLES : STAGE_DELAY;
    localparam int PHASE_MAX   = (LOCK_TIMEOUT > PHASE_MAX_A) ? LOCK_TIMEOUT : PHASE_MAX_A;
    localparam int PHASE_W     = $clog2(PHASE_MAX + 1);
    localparam int STABLE_W    = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [PHASE_W-1:0]  PLLRST_LAST  = PHASE_W'(PLLRST_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  TIMEOUT_LAST = PHASE_W'(LOCK_TIMEOUT - 1);
    localparam logic [PHASE_W-1:0]  STAGE_LAST   = PHASE_W'(STAGE_DELAY - 1);
    localparam logic [STABLE_W-1:0] STABLE_DONE  = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_FIRST = STABLE_W'(1);

    logic [LOCK_SYNC_STAGES-1:0] lockSync;
    logic                        lockS;
    state_t                      state;
    logic                        pllRst;
    logic [NUM_DOMAINS-1:0]      domainReset;
    logic                        allReady;
    logic [7:0]                  relockCount;
    logic [PHASE_W-1:0]          phaseCnt;
    logic [STABLE_W-1:0]         stableCnt;
    logic [NUM_DOMAINS-1:0]      nextReleased;
    logic                        lockLost;

    assign lockS = lockSync[LOCK_SYNC_STAGES-1];

    // Shifting in a zero at bit 0 releases the lowest still-asserted domain,
    // so releases can only happen one at a time and in index order.
    assign nextReleased = domainReset << 1;
    assign lockLost     = !lockS && (state == RELEASE || state == RUN);

    assign bus.pll_rst      = pllRst;
    assign bus.domain_reset = domainReset;
    assign bus.all_ready    = allReady;
    assign bus.state_dbg    = state;
    assign bus.relock_count = relockCount;

    // Bring the asynchronous PLL lock into the clock domain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lockSync <= '0;
        end else begin
            lockSync <= {lockSync[LOCK_SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    // Sequencing FSM; every output is a register updated here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= PLLRST;
            pllRst      <= 1'b1;
            domainReset <= '1;
            allReady    <= 1'b0;
            relockCount <= '0;
            phaseCnt    <= '0;
            stableCnt   <= '0;
        end else if (bus.sw_reset_req && state != PLLRST) begin
            // Software restart outranks a simultaneous lock loss.
            state       <= PLLRST;
            pllRst      <= 1'b1;
            domainReset <= '1;
            allReady    <= 1'b0;
            phaseCnt    <= '0;
            stableCnt   <= '0;
        end else if (lockLost) begin
            // The PLL relocks by itself, so skip the PLL pulse on lock loss.
            state       <= WAITLOCK;
            domainReset <= '1;
            allReady    <= 1'b0;
            phaseCnt    <= '0;
            stableCnt   <= '0;
            if (relockCount != 8'hFF) begin
                relockCount <= relockCount + 8'd1;
            end
        end else begin
            case (state)
                PLLRST: begin
                    if (phaseCnt == PLLRST_LAST) begin
                        state    <= WAITLOCK;
                        pllRst   <= 1'b0;
                        phaseCnt <= '0;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                WAITLOCK: begin
                    if (lockS) begin
                        state     <= STABLE;
                        stableCnt <= STABLE_FIRST;
                        phaseCnt  <= '0;
                    end else if (phaseCnt == TIMEOUT_LAST) begin
                        state    <= PLLRST;
                        pllRst   <= 1'b1;
                        phaseCnt <= '0;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lockS) begin
                        state     <= WAITLOCK;
                        phaseCnt  <= '0;
                        stableCnt <= '0;
                    end else if (stableCnt == STABLE_DONE) begin
                        domainReset <= nextReleased;
                        phaseCnt    <= '0;
                        stableCnt   <= '0;
                        if (nextReleased == '0) begin
                            state    <= RUN;
                            allReady <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        stableCnt <= stableCnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (phaseCnt == STAGE_LAST) begin
                        domainReset <= nextReleased;
                        phaseCnt    <= '0;
                        if (nextReleased == '0) begin
                            state    <= RUN;
                            allReady <= 1'b1;
                        end
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state       <= PLLRST;
                    pllRst      <= 1'b1;
                    domainReset <= '1;
                    allReady    <= 1'b0;
                    phaseCnt    <= '0;
                    stableCnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer. The driver steps a timestamp-based model of
// the sequence once per clock and queues every output change it predicts;
// the monitor pops one entry each time the DUT outputs change.
module tb_pll_reset_sequencer;
    localparam int ND        = 3;
    localparam int SYNC      = 2;
    localparam int STABLE_N  = 8;
    localparam int STAGE_N   = 4;
    localparam int PLLRST_N  = 4;
    localparam int TIMEOUT_N = 50;
    localparam int OUT_W     = ND + 13;

    localparam int ST_PLLRST = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_STABLE = 2;
    localparam int ST_REL    = 3;
    localparam int ST_RUN    = 4;

    localparam logic [OUT_W-1:0] RESET_VEC = {1'b1, {ND{1'b1}}, 1'b0, 3'd0, 8'd0};

    typedef struct {
        int               edgeNum;
        logic [OUT_W-1:0] val;
    } evt_t;

    logic clock = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   passCnt = 0;
    int   totalCnt = 0;
    evt_t expQ[$];

    // Reference model: state, edge at which it was entered, released count.
    int               mState;
    int               mEntry;
    int               mReleased;
    int               mRelock;
    int               edgeNo;
    logic             lockHist[$];
    logic [OUT_W-1:0] mLastOut;

    pll_reset_sequencer_if #(.NUM_DOMAINS(ND)) ifc ();

    pll_reset_sequencer #(
        .NUM_DOMAINS(ND),
        .LOCK_SYNC_STAGES(SYNC),
        .LOCK_STABLE_CYCLES(STABLE_N),
        .STAGE_DELAY(STAGE_N),
        .PLLRST_CYCLES(PLLRST_N),
        .LOCK_TIMEOUT(TIMEOUT_N)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(ifc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [OUT_W-1:0] dutOut();
        return {ifc.pll_rst, ifc.domain_reset, ifc.all_ready, ifc.state_dbg, ifc.relock_count};
    endfunction

    function automatic logic [OUT_W-1:0] modelOut();
        logic [ND-1:0] dr;
        dr = '1;
        for (int i = 0; i < ND; i++) if (i < mReleased) dr[i] = 1'b0;
        return {(mState == ST_PLLRST), dr, (mState == ST_RUN), 3'(mState), 8'(mRelock)};
    endfunction

    function automatic void modelEnter(input int st);
        mState = st;
        mEntry = edgeNo;
    endfunction

    function automatic void modelReleaseNext();
        mReleased++;
        modelEnter((mReleased == ND) ? ST_RUN : ST_REL);
    endfunction

    function automatic void modelReset();
        modelEnter(ST_PLLRST);
        mReleased = 0;
        mRelock   = 0;
        lockHist.delete();
        for (int i = 0; i < SYNC; i++) lockHist.push_back(1'b0);
    endfunction

    // Predict the outputs after the next edge and queue them if they change.
    function automatic void modelEdge(input logic lk, input logic sw, input logic rn);
        logic             lockS;
        int               age;
        logic [OUT_W-1:0] out;
        evt_t             e;
        edgeNo++;
        if (!rn) begin
            modelReset();
        end else begin
            lockS = lockHist.pop_front();
            lockHist.push_back(lk);
            age = edgeNo - mEntry;
            if (sw && mState != ST_PLLRST) begin
                modelEnter(ST_PLLRST);
                mReleased = 0;
            end else if (!lockS && (mState == ST_REL || mState == ST_RUN)) begin
                modelEnter(ST_WAIT);
                mReleased = 0;
                if (mRelock < 255) mRelock++;
            end else begin
                case (mState)
                    ST_PLLRST: if (age == PLLRST_N) modelEnter(ST_WAIT);
                    ST_WAIT: begin
                        if (lockS) modelEnter(ST_STABLE);
                        else if (age == TIMEOUT_N) modelEnter(ST_PLLRST);
                    end
                    ST_STABLE: begin
                        if (!lockS) modelEnter(ST_WAIT);
                        else if (age == STABLE_N) modelReleaseNext();
                    end
                    ST_REL: if (age == STAGE_N) modelReleaseNext();
                    default: ;
                endcase
            end
        end
        out = modelOut();
        if (out != mLastOut) begin
            e.edgeNum = edgeNo;
            e.val     = out;
            expQ.push_back(e);
        end
        mLastOut = out;
    endfunction

    // One clock of stimulus: inputs change on the falling edge.
    task automatic step(input logic lk, input logic sw, input logic rn);
        @(negedge clock);
        ifc.pll_locked   = lk;
        ifc.sw_reset_req = sw;
        if (!rn && resetn) begin
            resetn = 1'b0;
            #1;
            checkVal("async_reset", 32'(dutOut()), 32'(RESET_VEC));
        end else begin
            resetn = rn;
        end
        modelEdge(lk, sw, rn);
    endtask

    task automatic runUntilRelease(input string name);
        int n;
        n = 0;
        while (mState != ST_REL && n < 200) begin
            step(1'b1, 1'b0, 1'b1);
            n++;
        end
        checkVal(name, 32'(mState == ST_REL), 32'd1);
    endtask

    // Monitor: every change of the DUT outputs consumes one predicted event.
    initial begin
        logic [OUT_W-1:0] prev;
        logic [OUT_W-1:0] cur;
        evt_t             e;
        @(posedge clock);
        #1;
        prev = dutOut();
        checkVal("reset_state", 32'(prev), 32'(RESET_VEC));
        forever begin
            @(posedge clock);
            #1;
            cur = dutOut();
            if (cur !== prev) begin
                if (expQ.size() == 0) begin
                    checkVal("unexpected_change", 32'(cur), 32'(prev));
                end else begin
                    e = expQ.pop_front();
                    checkVal("event_edge", 32'(cyc), 32'(e.edgeNum));
                    checkVal("event_value", 32'(cur), 32'(e.val));
                end
                prev = cur;
            end
        end
    end

    // Driver: directed phases with randomized durations and pulses.
    initial begin
        int hi;
        int lo;
        resetn           = 1'b0;
        ifc.pll_locked   = 1'b0;
        ifc.sw_reset_req = 1'b0;
        edgeNo           = 1;
        modelReset();
        mLastOut = modelOut();

        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Nominal power-up.
        hi = $urandom_range(5, 15);
        repeat (hi) step(1'b0, 1'b0, 1'b1);
        repeat (40) step(1'b1, 1'b0, 1'b1);

        // Loss from RUN, then a one-cycle glitch part way through STABLE.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (7) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        repeat (30) step(1'b1, 1'b0, 1'b1);

        // Lock held low: repeated timeouts and PLL pulses.
        repeat (120) step(1'b0, 1'b0, 1'b1);
        repeat (40) step(1'b1, 1'b0, 1'b1);

        // Random lock glitches with occasional software requests.
        for (int r = 0; r < 30; r++) begin
            hi = $urandom_range(1, 30);
            lo = $urandom_range(1, 4);
            for (int c = 0; c < hi; c++) step(1'b1, ($urandom_range(0, 31) == 0), 1'b1);
            for (int c = 0; c < lo; c++) step(1'b0, 1'b0, 1'b1);
        end

        // Software request in RELEASE coinciding with a synchronised lock drop,
        // then a second request while the PLL pulse is running.
        step(1'b1, 1'b1, 1'b1);
        runUntilRelease("reach_release_sw");
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (40) step(1'b1, 1'b0, 1'b1);

        // Drive the relock counter into saturation.
        for (int r = 0; r < 260; r++) begin
            hi = $urandom_range(22, 30);
            for (int c = 0; c < hi; c++) step(1'b1, 1'b0, 1'b1);
            repeat (3) step(1'b0, 1'b0, 1'b1);
        end
        repeat (25) step(1'b1, 1'b0, 1'b1);
        checkVal("relock_saturated", 32'(ifc.relock_count), 32'd255);

        // Asynchronous reset in the middle of RELEASE, then a clean restart.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        runUntilRelease("reach_release_rst");
        hi = $urandom_range(1, 6);
        for (int c = 0; c < hi; c++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checkVal("relock_cleared", 32'(ifc.relock_count), 32'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0, 1'b1);
        checkVal("final_all_ready", 32'(ifc.all_ready), 32'd1);

        repeat (2) step(1'b1, 1'b0, 1'b1);
        @(posedge clock);
        #2;
        checkVal("pending_events", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
